dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data RAM between the openMSP430 core and one secondary bus master, such as a DES/DPA capture engine or a trace/loader unit. It sits between the core's dmem_* pins and the RAM instance. The core always has absolute priority, because openMSP430 has no wait-state support on data memory. The secondary master is granted only on cycles where the core does not access the RAM, and read data is steered back to whichever master owned the previous access.

## Interface
Parameters:
- AW, 10: RAM word-address width (matches dmem_addr).
- WAIT_MAX, 255: saturation value of the host wait counter; sets the starvation threshold.

Ports:
- mclk  in  1: clock. Core, arbiter and RAM share this one clock.
- puc_rst  in  1: reset, asynchronous, active-high.
- cpu_cen  in  1: core chip enable, low active.
- cpu_wen  in  2: core byte write enables, low active.
- cpu_addr  in  AW: core word address.
- cpu_din  in  16: core write data.
- cpu_dout  out  16: read data returned to the core.
- host_req  in  1: secondary master request; held with fields stable until host_gnt.
- host_we  in  1: 1 = write, 0 = read.
- host_be  in  2: byte enables, high active.
- host_addr  in  AW: host word address.
- host_wdata  in  16: host write data.
- host_gnt  out  1: one-cycle grant; the RAM access happens in this cycle.
- host_rvalid  out  1: pulses the cycle after a read grant.
- host_rdata  out  16: valid while host_rvalid=1.
- host_starved  out  1: sticky; set when the wait counter reaches WAIT_MAX.
- starve_clr  in  1: synchronous clear of host_starved and the wait counter.
- ram_cen  out  1: to RAM, low active.
- ram_wen  out  2: to RAM, low active.
- ram_addr  out  AW: to RAM.
- ram_din  out  16: to RAM.
- ram_dout  in  16: from RAM; valid one cycle after an enabled access.

## Operation
- **Grant rule.** host_gnt = host_req & cpu_cen & ~puc_rst. This path is combinational, so the grant is given in the same cycle as an idle core cycle.
- **RAM mux.** When cpu_cen=0, ram_* = cpu_* unchanged. When host_gnt=1, ram_cen=0, ram_wen=~host_be if host_we else 2'b11, ram_addr=host_addr, ram_din=host_wdata. Otherwise ram_cen=1, ram_wen=2'b11, and addr/din hold the core values.
- **Owner register.** Records the last access, with values NONE, CPU, HOST_RD and HOST_WR. It updates every cycle: CPU if cpu_cen=0, HOST_RD/HOST_WR if host_gnt=1, else NONE.
- **Core read data.** cpu_hold is a 16-bit register loaded with ram_dout on every cycle where owner=CPU.
  - cpu_dout = ram_dout when owner=CPU, else cpu_hold.
  - Result: a host access never disturbs data the core has already read.
- **Host read data.** host_rvalid = (owner==HOST_RD). host_rdata = ram_dout in that cycle. Host writes produce no rvalid.
- **Wait counter.**
  - Increments (saturating at WAIT_MAX) each cycle host_req=1 and host_gnt=0.
  - Clears on host_gnt.
  - Reaching WAIT_MAX sets host_starved.
  - starve_clr clears both the counter and host_starved; starve_clr wins over a simultaneous increment.
- **Byte writes.** host_be=2'b00 with host_we=1 is still granted: ram_cen=0, ram_wen=2'b11 (a no-op write). No rvalid follows.

## Timing
- **Reset values.** host_gnt=0, host_rvalid=0, host_rdata=ram_dout, host_starved=0, ram_cen=1, ram_wen=2'b11, cpu_dout=0 (cpu_hold=0, owner=NONE), wait counter=0.
- **Core path latency.** Zero added cycles. cpu_* to ram_* is combinational; core read data arrives 1 cycle after cpu_cen=0, exactly as with a direct connection.
- **Host read latency.** Data appears 1 cycle after host_gnt. Back-to-back grants are allowed on consecutive idle cycles, giving one access per cycle.
- **Simultaneous requests.** cpu_cen=0 and host_req=1 in the same cycle: the core wins, host_gnt=0 and the counter increments.
- **Reset mid-operation.** puc_rst asserted during host_rvalid cancels the rvalid. After reset releases, a still-held host_req is granted on the first idle cycle.

## Structure
- Shared package dmem_arb_pkg holds:
  - the owner_t enum (NONE, CPU, HOST_RD, HOST_WR);
  - the default AW and WAIT_MAX constants.
- Implementation is flat (combinational mux plus owner, hold and counter registers); no sub-module is natural.
- Instantiated in top between openMSP430 dmem_* and RAM_16x2k, with the same mclk domain as the RAM.

## Test plan
- **Idle core, host write then read.** With cpu_cen=1, host write addr=0x012, data=0xA5C3, be=2'b11, then host read addr=0x012. Expect host_gnt on each request cycle, and host_rvalid=1 with host_rdata=0xA5C3 one cycle after the read grant.
- **Contention.** Hold cpu_cen=0 for 5 cycles while host_req=1. Expect host_gnt=0 for all 5, the wait counter at 5, and a grant in the first cycle cpu_cen=1.
- **Core data protection.** Core reads addr=0x020 (0x1111). In the next cycle the host reads addr=0x021 (0x2222). Expect cpu_dout to stay 0x1111 through the host access and its rvalid cycle, and host_rdata=0x2222.
- **Byte write.** host be=2'b01, data=0xBEEF to a word holding 0x0000. Expect a readback of 0x00EF.
- **Starvation.** With WAIT_MAX=4, block the host for 4 cycles. Expect host_starved=1 that stays high after the grant; pulsing starve_clr clears it and the counter.
- **Reset mid-operation.** Assert puc_rst in the rvalid cycle. Expect host_rvalid=0, ram_cen=1 and host_gnt=0 immediately; after release, the held req is granted on the first idle cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter that lets a secondary
// bus master use the openMSP430 data RAM on cycles the core leaves idle.
package dmem_arb_pkg;

    // Who drove the RAM in the previous cycle; selects where ram_dout goes.
    typedef enum logic [1:0] {
        NONE    = 2'd0,
        CPU     = 2'd1,
        HOST_RD = 2'd2,
        HOST_WR = 2'd3
    } owner_t;

    localparam int DEFAULT_AW       = 10;
    localparam int DEFAULT_WAIT_MAX = 255;

endpackage

// File: rtl/dmem_arbiter.sv
// Core-priority arbiter for the single-port data RAM: the core path is a pure
// combinational pass-through, the host is served only on core-idle cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = DEFAULT_AW,
    parameter int WAIT_MAX = DEFAULT_WAIT_MAX
) (
    input  logic          mclk,
    input  logic          puc_rst,

    input  logic          cpu_cen,
    input  logic [1:0]    cpu_wen,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_din,
    output logic [15:0]   cpu_dout,

    input  logic          host_req,
    input  logic          host_we,
    input  logic [1:0]    host_be,
    input  logic [AW-1:0] host_addr,
    input  logic [15:0]   host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [15:0]   host_rdata,
    output logic          host_starved,
    input  logic          starve_clr,

    output logic          ram_cen,
    output logic [1:0]    ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_din,
    input  logic [15:0]   ram_dout
);

    localparam int                CW         = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]     WAIT_MAX_C = CW'(WAIT_MAX);

    owner_t          owner_q, owner_d;
    logic [15:0]     cpu_hold_q, cpu_hold_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            starved_q, starved_d;

    // Grant and RAM steering; the core never sees an added cycle.
    always_comb begin
        host_gnt = host_req & cpu_cen & ~puc_rst;
        ram_cen  = 1'b1;
        ram_wen  = 2'b11;
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        if (!cpu_cen) begin
            ram_cen = 1'b0;
            ram_wen = cpu_wen;
        end else if (host_gnt) begin
            ram_cen  = 1'b0;
            ram_wen  = host_we ? ~host_be : 2'b11;
            ram_addr = host_addr;
            ram_din  = host_wdata;
        end
    end

    always_comb begin
        owner_d = NONE;
        if (!cpu_cen) begin
            owner_d = CPU;
        end else if (host_gnt) begin
            owner_d = host_we ? HOST_WR : HOST_RD;
        end
    end

    // Keep the core's last read word so host traffic cannot overwrite it.
    always_comb begin
        cpu_hold_d = cpu_hold_q;
        if (owner_q == CPU) begin
            cpu_hold_d = ram_dout;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        starved_d  = starved_q;
        if (starve_clr) begin
            wait_cnt_d = '0;
            starved_d  = 1'b0;
        end else begin
            if (host_gnt) begin
                wait_cnt_d = '0;
            end else if (host_req && (wait_cnt_q != WAIT_MAX_C)) begin
                wait_cnt_d = wait_cnt_q + CW'(1);
            end
            if (wait_cnt_d == WAIT_MAX_C) begin
                starved_d = 1'b1;
            end
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            owner_q    <= NONE;
            cpu_hold_q <= 16'h0000;
            wait_cnt_q <= '0;
            starved_q  <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            cpu_hold_q <= cpu_hold_d;
            wait_cnt_q <= wait_cnt_d;
            starved_q  <= starved_d;
        end
    end

    always_comb begin
        cpu_dout     = (owner_q == CPU) ? ram_dout : cpu_hold_q;
        host_rvalid  = (owner_q == HOST_RD);
        host_rdata   = ram_dout;
        host_starved = starved_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port RAM; a second
// instance with a small WAIT_MAX exercises starvation on the same stimulus.
module tb_dmem_arbiter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_cen;
    logic [1:0]    cpu_wen;
    logic [AW-1:0] cpu_addr;
    logic [15:0]   cpu_din;
    logic [15:0]   cpu_dout;
    logic          host_req;
    logic          host_we;
    logic [1:0]    host_be;
    logic [AW-1:0] host_addr;
    logic [15:0]   host_wdata;
    logic          host_gnt;
    logic          host_rvalid;
    logic [15:0]   host_rdata;
    logic          host_starved;
    logic          starve_clr;
    logic          ram_cen;
    logic [1:0]    ram_wen;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_din;
    logic [15:0]   ram_dout = 16'h0000;

    logic [15:0]   s_cpu_dout;
    logic          s_gnt;
    logic          s_rvalid;
    logic [15:0]   s_rdata;
    logic          s_starved;
    logic          s_ram_cen;
    logic [1:0]    s_ram_wen;
    logic [AW-1:0] s_ram_addr;
    logic [15:0]   s_ram_din;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .WAIT_MAX(255)) dut (
        .mclk(clk), .puc_rst(rst),
        .cpu_cen(cpu_cen), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .host_req(host_req), .host_we(host_we), .host_be(host_be),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_starved(host_starved), .starve_clr(starve_clr),
        .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    dmem_arbiter #(.AW(AW), .WAIT_MAX(4)) dut4 (
        .mclk(clk), .puc_rst(rst),
        .cpu_cen(cpu_cen), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(s_cpu_dout),
        .host_req(host_req), .host_we(host_we), .host_be(host_be),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(s_gnt), .host_rvalid(s_rvalid), .host_rdata(s_rdata),
        .host_starved(s_starved), .starve_clr(starve_clr),
        .ram_cen(s_ram_cen), .ram_wen(s_ram_wen), .ram_addr(s_ram_addr),
        .ram_din(s_ram_din), .ram_dout(ram_dout)
    );

    // Single-port RAM, one-cycle read latency, active-low byte write enables.
    always @(posedge clk) begin
        if (!ram_cen) begin
            if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
            if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let combinational paths settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic host_set(input logic req, input logic we, input logic [1:0] be,
                            input logic [AW-1:0] addr, input logic [15:0] data);
        host_req   = req;
        host_we    = we;
        host_be    = be;
        host_addr  = addr;
        host_wdata = data;
    endtask

    task automatic host_write(input string tag, input logic [AW-1:0] addr,
                              input logic [1:0] be, input logic [15:0] data);
        host_set(1'b1, 1'b1, be, addr, data);
        settle();
        chk_eq(tag, {31'd0, host_gnt}, 32'd1);
        tick();
        host_set(1'b0, 1'b0, 2'b00, '0, 16'h0000);
    endtask

    task automatic host_read_check(input string tag, input logic [AW-1:0] addr,
                                   input logic [15:0] exp);
        host_set(1'b1, 1'b0, 2'b11, addr, 16'h0000);
        settle();
        chk_eq({tag, "_gnt"}, {31'd0, host_gnt}, 32'd1);
        tick();
        host_set(1'b0, 1'b0, 2'b00, '0, 16'h0000);
        settle();
        chk_eq({tag, "_rvalid"}, {31'd0, host_rvalid}, 32'd1);
        chk_eq({tag, "_rdata"}, {16'd0, host_rdata}, {16'd0, exp});
    endtask

    initial begin
        rst        = 1'b1;
        cpu_cen    = 1'b1;
        cpu_wen    = 2'b11;
        cpu_addr   = '0;
        cpu_din    = 16'h0000;
        starve_clr = 1'b0;
        host_set(1'b1, 1'b0, 2'b11, 10'h012, 16'h0000);

        // Reset state, with a pending host request that must not be granted.
        tick();
        tick();
        chk_eq("rst_gnt",     {31'd0, host_gnt},     32'd0);
        chk_eq("rst_rvalid",  {31'd0, host_rvalid},  32'd0);
        chk_eq("rst_starved", {31'd0, host_starved}, 32'd0);
        chk_eq("rst_ram_cen", {31'd0, ram_cen},      32'd1);
        chk_eq("rst_ram_wen", {30'd0, ram_wen},      32'd3);
        chk_eq("rst_cpu_dout", {16'd0, cpu_dout},    32'd0);
        chk_eq("rst_wait",    32'(dut.wait_cnt_q),   32'd0);
        host_set(1'b0, 1'b0, 2'b00, '0, 16'h0000);
        rst = 1'b0;
        tick();

        // Idle core: host write then read back.
        host_set(1'b1, 1'b1, 2'b11, 10'h012, 16'hA5C3);
        settle();
        chk_eq("wr_gnt",      {31'd0, host_gnt},  32'd1);
        chk_eq("wr_ram_cen",  {31'd0, ram_cen},   32'd0);
        chk_eq("wr_ram_wen",  {30'd0, ram_wen},   32'd0);
        chk_eq("wr_ram_addr", 32'(ram_addr),      32'h012);
        chk_eq("wr_ram_din",  {16'd0, ram_din},   32'hA5C3);
        tick();
        host_set(1'b1, 1'b0, 2'b11, 10'h012, 16'h0000);
        settle();
        chk_eq("rd_gnt",      {31'd0, host_gnt},    32'd1);
        chk_eq("rd_ram_wen",  {30'd0, ram_wen},     32'd3);
        chk_eq("wr_no_rvalid", {31'd0, host_rvalid}, 32'd0);
        tick();
        host_set(1'b0, 1'b0, 2'b00, '0, 16'h0000);
        settle();
        chk_eq("rd_rvalid", {31'd0, host_rvalid}, 32'd1);
        chk_eq("rd_rdata",  {16'd0, host_rdata},  32'hA5C3);
        tick();
        chk_eq("rd_rvalid_drop", {31'd0, host_rvalid}, 32'd0);

        // Preload words used by the core-protection and contention phases.
        host_write("pre20_gnt", 10'h020, 2'b11, 16'h1111);
        host_write("pre21_gnt", 10'h021, 2'b11, 16'h2222);
        host_write("pre30_gnt", 10'h030, 2'b11, 16'h0000);

        // Contention: core busy 5 cycles, host held off and counter climbs.
        cpu_cen  = 1'b0;
        cpu_wen  = 2'b11;
        cpu_addr = 10'h040;
        host_set(1'b1, 1'b0, 2'b11, 10'h021, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk_eq($sformatf("cont_gnt%0d", i), {31'd0, host_gnt}, 32'd0);
            if (i == 0) chk_eq("cont_ram_addr", 32'(ram_addr), 32'h040);
            tick();
        end
        cpu_cen = 1'b1;
        settle();
        chk_eq("cont_wait5",    32'(dut.wait_cnt_q),  32'd5);
        chk_eq("cont_gnt_idle", {31'd0, host_gnt},    32'd1);
        tick();
        host_set(1'b0, 1'b0, 2'b00, '0, 16'h0000);
        settle();
        chk_eq("cont_wait_clr", 32'(dut.wait_cnt_q),  32'd0);
        chk_eq("cont_rdata",    {16'd0, host_rdata},  32'h2222);
        tick();

        // Core reads 0x020, host reads 0x021 in the next cycle.
        cpu_cen  = 1'b0;
        cpu_addr = 10'h020;
        tick();
        cpu_cen = 1'b1;
        host_set(1'b1, 1'b0, 2'b11, 10'h021, 16'h0000);
        settle();
        chk_eq("prot_cpu_c1", {16'd0, cpu_dout}, 32'h1111);
        chk_eq("prot_gnt",    {31'd0, host_gnt}, 32'd1);
        tick();
        host_set(1'b0, 1'b0, 2'b00, '0, 16'h0000);
        settle();
        chk_eq("prot_cpu_c2", {16'd0, cpu_dout},    32'h1111);
        chk_eq("prot_rvalid", {31'd0, host_rvalid}, 32'd1);
        chk_eq("prot_rdata",  {16'd0, host_rdata},  32'h2222);
        tick();
        chk_eq("prot_cpu_c3", {16'd0, cpu_dout},    32'h1111);

        // Low-byte write into a zero word, then an all-disabled write.
        host_write("bw_gnt", 10'h030, 2'b01, 16'hBEEF);
        host_read_check("bw_rd", 10'h030, 16'h00EF);
        host_set(1'b1, 1'b1, 2'b00, 10'h030, 16'hFFFF);
        settle();
        chk_eq("be0_gnt",     {31'd0, host_gnt}, 32'd1);
        chk_eq("be0_ram_cen", {31'd0, ram_cen},  32'd0);
        chk_eq("be0_ram_wen", {30'd0, ram_wen},  32'd3);
        tick();
        host_set(1'b0, 1'b0, 2'b00, '0, 16'h0000);
        settle();
        chk_eq("be0_no_rvalid", {31'd0, host_rvalid}, 32'd0);
        host_read_check("be0_rd", 10'h030, 16'h00EF);

        // Starvation on the WAIT_MAX=4 instance; it saturated during contention.
        chk_eq("stv_sticky_prev", {31'd0, s_starved}, 32'd1);
        starve_clr = 1'b1;
        tick();
        starve_clr = 1'b0;
        chk_eq("stv_clr0",      {31'd0, s_starved},    32'd0);
        chk_eq("stv_clr0_wait", 32'(dut4.wait_cnt_q),  32'd0);
        cpu_cen = 1'b0;
        host_set(1'b1, 1'b0, 2'b11, 10'h012, 16'h0000);
        for (int i = 0; i < 3; i++) tick();
        chk_eq("stv_not_yet", {31'd0, s_starved}, 32'd0);
        tick();
        chk_eq("stv_set",      {31'd0, s_starved},   32'd1);
        chk_eq("stv_wait4",    32'(dut4.wait_cnt_q), 32'd4);
        chk_eq("stv_big_none", {31'd0, host_starved}, 32'd0);
        tick();
        chk_eq("stv_wait_sat", 32'(dut4.wait_cnt_q), 32'd4);
        cpu_cen = 1'b1;
        settle();
        chk_eq("stv_gnt", {31'd0, s_gnt}, 32'd1);
        tick();
        chk_eq("stv_hold",      {31'd0, s_starved},   32'd1);
        chk_eq("stv_wait_gnt0", 32'(dut4.wait_cnt_q), 32'd0);
        cpu_cen    = 1'b0;
        starve_clr = 1'b1;
        tick();
        starve_clr = 1'b0;
        chk_eq("stv_clr",      {31'd0, s_starved},   32'd0);
        chk_eq("stv_clr_wait", 32'(dut4.wait_cnt_q), 32'd0);
        cpu_cen = 1'b1;
        host_set(1'b0, 1'b0, 2'b00, '0, 16'h0000);
        tick();

        // Reset asserted in the rvalid cycle; held request granted after release.
        host_set(1'b1, 1'b0, 2'b11, 10'h012, 16'h0000);
        tick();
        chk_eq("rmo_rvalid_pre", {31'd0, host_rvalid}, 32'd1);
        rst = 1'b1;
        settle();
        chk_eq("rmo_rvalid", {31'd0, host_rvalid}, 32'd0);
        chk_eq("rmo_ram_cen", {31'd0, ram_cen},    32'd1);
        chk_eq("rmo_gnt",    {31'd0, host_gnt},    32'd0);
        tick();
        rst     = 1'b0;
        cpu_cen = 1'b0;
        settle();
        chk_eq("rmo_busy_gnt", {31'd0, host_gnt}, 32'd0);
        tick();
        cpu_cen = 1'b1;
        settle();
        chk_eq("rmo_regnt", {31'd0, host_gnt}, 32'd1);
        tick();
        host_set(1'b0, 1'b0, 2'b00, '0, 16'h0000);
        settle();
        chk_eq("rmo_rdata", {16'd0, host_rdata}, 32'hA5C3);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
